uart_resp_arb: RTL and testbench

Round-robin arbiter that shares the single UART transmit path (trmt / resp / tx_done of the UART wrapper) among several on-chip requesters: command-processor acks, tour-status bytes and diagnostics. It grants one requester at a time and launches that requester's byte with a one-cycle trmt pulse. It then holds off further grants until the UART reports completion, or until a watchdog timeout expires. It sits between the requesters and the UART wrapper's trmt/resp/tx_done pins.

---
 rtl/uart_resp_arb.sv | 148 ++++++++++++++
 tb/tb_uart_resp_arb.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_resp_arb.sv
`default_nettype none
// ============================================================================
// Module   : uart_resp_arb
// Brief    : Round-robin arbiter sharing one UART transmit path (trmt/resp/
//            tx_done) among NREQ byte requesters, with a WAIT watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module uart_resp_arb #(
    parameter int NREQ    = 3,
    parameter int TMO_CYC = 32768
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   ack,
    output logic [NREQ-1:0]   cmplt,
    output logic              tmo,
    output logic              busy,
    output logic              trmt,
    output logic [7:0]        resp,
    input  logic              tx_done
);

    localparam int            c_id_w    = $clog2(NREQ);
    localparam int            c_cnt_w   = $clog2(TMO_CYC);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(TMO_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    state_t              r_state, w_state;
    logic [c_id_w-1:0]   r_id, w_id;
    logic [c_id_w-1:0]   r_last, w_last;
    logic [c_cnt_w-1:0]  r_cnt, w_cnt;
    logic                r_txd_q;

    logic                w_trmt, w_tmo, w_busy, w_done;
    logic [NREQ-1:0]     w_ack, w_cmplt, w_win_1h, w_id_1h;
    logic [7:0]          w_resp, w_win_data;
    logic [c_id_w-1:0]   w_win;

    // First set bit of r searching l+1, l+2, ... modulo NREQ; the descending
    // loop lets the smallest offset overwrite the others.
    function automatic logic [c_id_w-1:0] rr_pick(input logic [NREQ-1:0]   r,
                                                  input logic [c_id_w-1:0] l);
        logic [c_id_w-1:0] win;
        logic [c_id_w-1:0] idx;
        win = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = c_id_w'((int'(l) + k) % NREQ);
            if (r[idx]) win = idx;
        end
        return win;
    endfunction

    // Only a rising edge counts, so a tx_done left high by the previous frame is ignored.
    assign w_done = tx_done & ~r_txd_q;

    always_comb begin
        w_state    = r_state;
        w_trmt     = 1'b0;
        w_ack      = '0;
        w_cmplt    = '0;
        w_tmo      = 1'b0;
        w_busy     = 1'b0;
        w_resp     = resp;
        w_id       = r_id;
        w_last     = r_last;
        w_cnt      = r_cnt;
        w_win      = rr_pick(req, r_last);
        w_win_1h   = '0;
        w_win_data = '0;
        w_id_1h    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win == c_id_w'(i)) begin
                w_win_1h[i] = 1'b1;
                w_win_data  = req_data[8*i +: 8];
            end
            if (r_id == c_id_w'(i)) w_id_1h[i] = 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_state = S_LAUNCH;
                    w_trmt  = 1'b1;
                    w_ack   = w_win_1h;
                    w_busy  = 1'b1;
                    w_resp  = w_win_data;
                    w_id    = w_win;
                    w_last  = w_win;
                end
            end
            S_LAUNCH: begin
                w_cnt   = '0;
                w_busy  = 1'b1;
                w_state = S_WAIT;
            end
            S_WAIT: begin
                if (w_done) begin
                    w_cmplt = w_id_1h;
                    w_state = S_IDLE;
                end else if (r_cnt == c_cnt_max) begin
                    w_tmo   = 1'b1;
                    w_state = S_IDLE;
                end else begin
                    w_cnt  = r_cnt + c_cnt_w'(1);
                    w_busy = 1'b1;
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_id    <= '0;
            r_last  <= c_id_w'(NREQ - 1);
            r_cnt   <= '0;
            r_txd_q <= 1'b0;
            trmt    <= 1'b0;
            ack     <= '0;
            cmplt   <= '0;
            tmo     <= 1'b0;
            busy    <= 1'b0;
            resp    <= 8'h00;
        end else begin
            r_state <= w_state;
            r_id    <= w_id;
            r_last  <= w_last;
            r_cnt   <= w_cnt;
            r_txd_q <= tx_done;
            trmt    <= w_trmt;
            ack     <= w_ack;
            cmplt   <= w_cmplt;
            tmo     <= w_tmo;
            busy    <= w_busy;
            resp    <= w_resp;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_resp_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_resp_arb
// Brief    : Self-checking bench for uart_resp_arb against a cycle-time model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_resp_arb;

    localparam int NREQ    = 3;
    localparam int TMO_CYC = 64;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   ack, cmplt;
    logic              tmo, busy, trmt, tx_done;
    logic [7:0]        resp;

    uart_resp_arb #(.NREQ(NREQ), .TMO_CYC(TMO_CYC)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_data (req_data),
        .ack      (ack),
        .cmplt    (cmplt),
        .tmo      (tmo),
        .busy     (busy),
        .trmt     (trmt),
        .resp     (resp),
        .tx_done  (tx_done)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    bit exp_valid = 1'b0;

    // expected outputs for the coming cycle
    logic [NREQ-1:0] e_ack, e_cmplt;
    logic            e_tmo, e_trmt, e_busy;
    logic [7:0]      e_resp;

    // model: a transfer is "active" from grant until completion/timeout;
    // its watch window opens at m_wait0 (two cycles after the grant sample)
    bit m_act;
    int m_last, m_cur, m_wait0;
    bit m_txq;

    // UART model and requester policy
    int lat = 20;
    bit stale = 1'b0;
    int fall_at = -1, rise_at = -1;
    bit auto_rereq = 1'b0;
    int rand_rate = 0;
    bit rand_drop = 1'b0;
    bit [NREQ-1:0]   rr_pend = '0;
    logic [NREQ-1:0] ack_obs;

    int ack_log[$];
    int last_trmt_cyc, last_tmo_cyc, last_cmplt_cyc, t1;
    int n_cmplt_ev = 0, n_tmo_ev = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    endtask

    function automatic int rr_pick(input bit [NREQ-1:0] r, input int l);
        for (int k = 1; k <= NREQ; k++)
            if (r[(l + k) % NREQ]) return (l + k) % NREQ;
        return -1;
    endfunction

    task automatic model_step();
        int w;
        e_ack   = '0;
        e_cmplt = '0;
        e_trmt  = 1'b0;
        e_tmo   = 1'b0;
        exp_valid = 1'b1;
        if (!rst_n) begin
            m_act  = 1'b0;
            m_last = NREQ - 1;
            m_txq  = 1'b0;
            e_resp = 8'h00;
            e_busy = 1'b0;
            return;
        end
        if (!m_act) begin
            if (req != '0) begin
                w         = rr_pick(req, m_last);
                e_ack[w]  = 1'b1;
                e_trmt    = 1'b1;
                e_resp    = req_data[8*w +: 8];
                m_act     = 1'b1;
                m_wait0   = cyc + 2;
                m_last    = w;
                m_cur     = w;
            end
        end else if (cyc >= m_wait0) begin
            if (tx_done && !m_txq) begin
                e_cmplt[m_cur] = 1'b1;
                m_act = 1'b0;
            end else if (cyc - m_wait0 == TMO_CYC - 1) begin
                e_tmo = 1'b1;
                m_act = 1'b0;
            end
        end
        e_busy = m_act;
        m_txq  = tx_done;
    endtask

    task automatic step();
        @(negedge clk);
        if (exp_valid) begin
            chk("ack",   ack,   e_ack);
            chk("trmt",  trmt,  e_trmt);
            chk("cmplt", cmplt, e_cmplt);
            chk("tmo",   tmo,   e_tmo);
            chk("busy",  busy,  e_busy);
            chk("resp",  resp,  e_resp);
        end
        ack_obs = ack;
        for (int i = 0; i < NREQ; i++) if (ack[i] === 1'b1) ack_log.push_back(i);
        if (trmt === 1'b1) begin
            last_trmt_cyc = cyc;
            fall_at = cyc + (stale ? 2 : 1);
            rise_at = (lat < 0) ? -1 : cyc + lat;
        end
        if (tmo === 1'b1) begin last_tmo_cyc = cyc; n_tmo_ev++; end
        if (cmplt !== '0) begin last_cmplt_cyc = cyc; n_cmplt_ev++; end
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        if (!rst_n) begin fall_at = -1; rise_at = -1; tx_done = 1'b0; end
        if (cyc == fall_at) tx_done = 1'b0;
        if (cyc == rise_at) tx_done = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            if (ack_obs[i] === 1'b1) begin
                req[i] = 1'b0;
                rr_pend[i] = auto_rereq;
            end else if (rr_pend[i]) begin
                req[i] = 1'b1;
                req_data[8*i +: 8] = 8'($urandom);
                rr_pend[i] = 1'b0;
            end else if (!req[i] && rand_rate != 0 && $urandom_range(99) < rand_rate) begin
                req[i] = 1'b1;
                req_data[8*i +: 8] = 8'($urandom);
            end else if (req[i] && rand_drop && $urandom_range(99) < 3) begin
                req[i] = 1'b0;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; req = '0; req_data = '0; tx_done = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;

        // single request
        ack_log.delete(); n_cmplt_ev = 0; lat = 40;
        req_data[15:8] = 8'hA5; req[1] = 1'b1;
        repeat (60) step();
        chk("single_grant", ack_log.size() == 1 ? ack_log[0] : -1, 1);
        chk("single_cmplt_lat", last_cmplt_cyc - last_trmt_cyc, 41);
        chk("single_cmplt_cnt", n_cmplt_ev, 1);
        chk("single_resp", resp, 8'hA5);
        chk("single_busy", busy, 1'b0);

        // simultaneous requests from a fresh reset
        rst_n = 1'b0; step(); rst_n = 1'b1;
        ack_log.delete(); auto_rereq = 1'b1; lat = 10;
        req_data = {8'h33, 8'h22, 8'h11}; req = '1;
        for (int g = 0; g < 300 && ack_log.size() < 6; g++) step();
        auto_rereq = 1'b0; rr_pend = '0;
        chk("simul_count", ack_log.size(), 6);
        for (int i = 0; i < ack_log.size() && i < 6; i++) chk("simul_order", ack_log[i], i % 3);
        req = '0;
        repeat (40) step();

        // stale tx_done across launch
        tx_done = 1'b1; stale = 1'b1; lat = 52; n_cmplt_ev = 0;
        req_data[23:16] = 8'h5A; req[2] = 1'b1;
        repeat (70) step();
        chk("stale_cmplt_cnt", n_cmplt_ev, 1);
        chk("stale_cmplt_lat", last_cmplt_cyc - last_trmt_cyc, 53);
        stale = 1'b0;

        // timeout, then pending requester granted
        lat = -1; n_cmplt_ev = 0; n_tmo_ev = 0; ack_log.delete();
        req_data[7:0] = 8'hC3; req[0] = 1'b1;
        repeat (4) step();
        t1 = last_trmt_cyc;
        lat = 20; req_data[23:16] = 8'h3C; req[2] = 1'b1;
        repeat (100) step();
        chk("tmo_cnt", n_tmo_ev, 1);
        chk("tmo_lat", last_tmo_cyc - t1, TMO_CYC + 1);
        chk("tmo_cmplt_cnt", n_cmplt_ev, 1);
        chk("tmo_next_grant", ack_log.size() == 2 ? ack_log[1] : -1, 2);
        chk("tmo_next_trmt", last_trmt_cyc - last_tmo_cyc, 1);

        // completion on the last watchdog cycle
        lat = TMO_CYC; n_cmplt_ev = 0; n_tmo_ev = 0;
        req_data[15:8] = 8'h96; req[1] = 1'b1;
        repeat (80) step();
        chk("both_cmplt", n_cmplt_ev, 1);
        chk("both_tmo", n_tmo_ev, 0);
        chk("both_lat", last_cmplt_cyc - last_trmt_cyc, TMO_CYC + 1);

        // randomized traffic with occasional resets
        rand_rate = 8; rand_drop = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            lat   = ($urandom_range(7) == 0) ? -1 : int'($urandom_range(70, 2));
            rst_n = ($urandom_range(400) != 0);
            step();
        end
        rst_n = 1'b1; rand_rate = 0; rand_drop = 1'b0; req = '0;
        repeat (80) step();
        chk("drain_busy", busy, 1'b0);

        // reset during WAIT
        lat = -1; req[0] = 1'b1;
        repeat (6) step();
        chk("rst_pre_busy", busy, 1'b1);
        req = 3'b101; rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        ack_log.delete();
        repeat (5) step();
        chk("rst_next_grant", ack_log.size() > 0 ? ack_log[0] : -1, 0);
        lat = 5;
        repeat (100) step();
        req = '0;
        repeat (20) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire
